// File: rtl/io_out_ctrl.sv
// io_out_ctrl: CPU output-port controller.
// Turns io_write strobes into write events and queues io_data words in a
// first-word-fall-through FIFO. Words drain to a sink over valid/ready.
// When the FIFO is full, the controller raises cpu_stall. Words that arrive
// while the FIFO is full are dropped and counted. All outputs come only from
// registered state.
module io_out_ctrl #(
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 8,
  parameter int EDGE_DET = 1,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     io_write,
  input  logic [DATA_W-1:0]        io_data,
  output logic                     cpu_stall,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         overflow_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  // Storage has no reset; the pointers and the level decide which entries are live.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              prev_write_q, prev_write_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  ovf_cnt_q, ovf_cnt_d;

  logic              ev;
  logic              pop;
  logic              push;
  logic              drop;

  // Outputs decode registered state only, so no input reaches them in the same cycle.
  assign out_valid    = (level_q != {LVL_W{1'b0}});
  assign cpu_stall    = (level_q == FULL_LVL);
  assign out_data     = mem_q[rd_ptr_q];
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign overflow_cnt = ovf_cnt_q;

  // Event detection and the push/pop/drop decisions for this cycle.
  always_comb begin
    ev   = 1'b0;
    pop  = 1'b0;
    push = 1'b0;
    drop = 1'b0;
    if (EDGE_DET != 0) begin
      ev = io_write & ~prev_write_q;
    end else begin
      ev = io_write;
    end
    pop  = out_valid & out_ready;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    push = ev & ((level_q < FULL_LVL) | pop);
    drop = ev & ~push;
  end

  // Next-state logic for the pointers, the occupancy, the strobe history and the overflow tracking.
  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    level_d      = level_q;
    prev_write_d = io_write;
    overflow_d   = overflow_q;
    ovf_cnt_d    = ovf_cnt_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    if (drop) begin
      overflow_d = 1'b1;
      // The count saturates at all-ones and does not wrap.
      if (&ovf_cnt_q) begin
        ovf_cnt_d = ovf_cnt_q;
      end else begin
        ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
      end
    end else begin
      overflow_d = overflow_q;
      ovf_cnt_d  = ovf_cnt_q;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q     <= {PTR_W{1'b0}};
      wr_ptr_q     <= {PTR_W{1'b0}};
      level_q      <= {LVL_W{1'b0}};
      prev_write_q <= 1'b0;
      overflow_q   <= 1'b0;
      ovf_cnt_q    <= {CNT_W{1'b0}};
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      level_q      <= level_d;
      prev_write_q <= prev_write_d;
      overflow_q   <= overflow_d;
      ovf_cnt_q    <= ovf_cnt_d;
    end
  end

  // Write the accepted word into the tail slot; reset does not clear the storage.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= io_data;
    end
  end

endmodule

// File: tb/tb_io_out_ctrl.sv
// Self-checking bench for io_out_ctrl.
// Instance dut uses the default parameters and runs from a table of vectors.
// Instance dut2 uses CNT_W=2 and EDGE_DET=0 and runs a hand-written sequence
// for level-triggered writes and counter saturation.
module tb_io_out_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        io_write;
  logic [63:0] io_data;
  logic        out_ready;
  logic        cpu_stall, out_valid, overflow;
  logic [63:0] out_data;
  logic [3:0]  level;
  logic [15:0] overflow_cnt;

  logic        io_write2;
  logic [63:0] io_data2;
  logic        out_ready2;
  logic        cpu_stall2, out_valid2, overflow2;
  logic [63:0] out_data2;
  logic [3:0]  level2;
  logic [1:0]  overflow_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  io_out_ctrl #(.DATA_W(64), .DEPTH(8), .EDGE_DET(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .io_write(io_write), .io_data(io_data),
    .cpu_stall(cpu_stall), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .level(level), .overflow(overflow),
    .overflow_cnt(overflow_cnt)
  );

  io_out_ctrl #(.DATA_W(64), .DEPTH(8), .EDGE_DET(0), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .io_write(io_write2), .io_data(io_data2),
    .cpu_stall(cpu_stall2), .out_valid(out_valid2), .out_data(out_data2),
    .out_ready(out_ready2), .level(level2), .overflow(overflow2),
    .overflow_cnt(overflow_cnt2)
  );

  typedef struct {
    logic        rst;
    logic        wr;
    logic [63:0] d;
    logic        rdy;
    logic [3:0]  lvl;
    logic [63:0] head;
    logic        ovf;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic w, input logic [63:0] d, input logic rdy,
                     input logic [3:0] lvl, input logic [63:0] head,
                     input logic ovf, input logic [15:0] cnt);
    vec_t v;
    v.rst = r; v.wr = w; v.d = d; v.rdy = rdy;
    v.lvl = lvl; v.head = head; v.ovf = ovf; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  initial begin
    logic [63:0] tail [8];

    // Reset and idle.
    add(1'b1, 1'b0, 64'd0, 1'b0, 4'd0, 64'd0, 1'b0, 16'd0);
    add(1'b0, 1'b0, 64'd0, 1'b0, 4'd0, 64'd0, 1'b0, 16'd0);
    // io_write held high for 3 cycles with out_ready=1 gives one word, valid for one cycle.
    add(1'b0, 1'b1, 64'd42, 1'b1, 4'd1, 64'd42, 1'b0, 16'd0);
    add(1'b0, 1'b1, 64'd42, 1'b1, 4'd0, 64'd0, 1'b0, 16'd0);
    add(1'b0, 1'b1, 64'd42, 1'b1, 4'd0, 64'd0, 1'b0, 16'd0);
    add(1'b0, 1'b0, 64'd0, 1'b1, 4'd0, 64'd0, 1'b0, 16'd0);
    // Fill with pulses carrying 1..8 while out_ready=0.
    for (int k = 1; k <= 8; k++) begin
      add(1'b0, 1'b1, 64'(k), 1'b0, 4'(k), 64'd1, 1'b0, 16'd0);
      add(1'b0, 1'b0, 64'd0, 1'b0, 4'(k), 64'd1, 1'b0, 16'd0);
    end
    // A 9th pulse while full is dropped.
    add(1'b0, 1'b1, 64'd9, 1'b0, 4'd8, 64'd1, 1'b1, 16'd1);
    add(1'b0, 1'b0, 64'd0, 1'b0, 4'd8, 64'd1, 1'b1, 16'd1);
    // Full, with a pop and a push in the same cycle: no drop, level stays 8.
    add(1'b0, 1'b1, 64'd100, 1'b1, 4'd8, 64'd2, 1'b1, 16'd1);
    // Drain: 2..8 then 100, in order.
    tail[0] = 64'd3; tail[1] = 64'd4; tail[2] = 64'd5; tail[3] = 64'd6;
    tail[4] = 64'd7; tail[5] = 64'd8; tail[6] = 64'd100; tail[7] = 64'd0;
    for (int j = 0; j < 8; j++) begin
      add(1'b0, 1'b0, 64'd0, 1'b1, 4'(7 - j), tail[j], 1'b1, 16'd1);
    end
    // Queue 3 words under backpressure, then toggle out_ready.
    add(1'b0, 1'b1, 64'd11, 1'b0, 4'd1, 64'd11, 1'b1, 16'd1);
    add(1'b0, 1'b0, 64'd0,  1'b0, 4'd1, 64'd11, 1'b1, 16'd1);
    add(1'b0, 1'b1, 64'd12, 1'b0, 4'd2, 64'd11, 1'b1, 16'd1);
    add(1'b0, 1'b0, 64'd0,  1'b0, 4'd2, 64'd11, 1'b1, 16'd1);
    add(1'b0, 1'b1, 64'd13, 1'b0, 4'd3, 64'd11, 1'b1, 16'd1);
    add(1'b0, 1'b0, 64'd0,  1'b0, 4'd3, 64'd11, 1'b1, 16'd1);
    add(1'b0, 1'b0, 64'd0,  1'b1, 4'd2, 64'd12, 1'b1, 16'd1);
    add(1'b0, 1'b0, 64'd0,  1'b0, 4'd2, 64'd12, 1'b1, 16'd1);
    add(1'b0, 1'b0, 64'd0,  1'b1, 4'd1, 64'd13, 1'b1, 16'd1);
    add(1'b0, 1'b0, 64'd0,  1'b0, 4'd1, 64'd13, 1'b1, 16'd1);
    add(1'b0, 1'b0, 64'd0,  1'b1, 4'd0, 64'd0,  1'b1, 16'd1);
    // Queue 5 words, then reset mid-operation with io_write already high.
    for (int k = 1; k <= 5; k++) begin
      add(1'b0, 1'b1, 64'(20 + k), 1'b0, 4'(k), 64'd21, 1'b1, 16'd1);
      add(1'b0, 1'b0, 64'd0, 1'b0, 4'(k), 64'd21, 1'b1, 16'd1);
    end
    add(1'b1, 1'b1, 64'd99, 1'b1, 4'd0, 64'd0, 1'b0, 16'd0);
    // io_write is still high in the first cycle after reset, so this counts as an event.
    add(1'b0, 1'b1, 64'd7, 1'b0, 4'd1, 64'd7, 1'b0, 16'd0);
    add(1'b0, 1'b0, 64'd0, 1'b1, 4'd0, 64'd0, 1'b0, 16'd0);

    rst = 1'b1; io_write = 1'b0; io_data = 64'd0; out_ready = 1'b0;
    io_write2 = 1'b0; io_data2 = 64'd0; out_ready2 = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      rst       = vecs[i].rst;
      io_write  = vecs[i].wr;
      io_data   = vecs[i].d;
      out_ready = vecs[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.level", i), 64'(level), 64'(vecs[i].lvl));
      chk($sformatf("v%0d.out_valid", i), 64'(out_valid), 64'(vecs[i].lvl != 4'd0));
      chk($sformatf("v%0d.cpu_stall", i), 64'(cpu_stall), 64'(vecs[i].lvl == 4'd8));
      chk($sformatf("v%0d.overflow", i), 64'(overflow), 64'(vecs[i].ovf));
      chk($sformatf("v%0d.overflow_cnt", i), 64'(overflow_cnt), 64'(vecs[i].cnt));
      if (vecs[i].lvl != 4'd0) begin
        chk($sformatf("v%0d.out_data", i), out_data, vecs[i].head);
      end else begin
        checks = checks;
      end
    end

    // Level-triggered instance: clean reset, then io_write held high, out_ready low.
    rst = 1'b1; io_write = 1'b0; io_write2 = 1'b0; out_ready2 = 1'b0;
    @(posedge clk); #1;
    chk("d2.reset_level", 64'(level2), 64'd0);
    chk("d2.reset_cnt", 64'(overflow_cnt2), 64'd0);
    rst = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      io_write2 = 1'b1;
      io_data2  = 64'(k);
      @(posedge clk); #1;
      chk($sformatf("d2.fill%0d.level", k), 64'(level2), 64'((k < 8) ? k : 8));
      chk($sformatf("d2.fill%0d.cnt", k), 64'(overflow_cnt2), 64'((k <= 8) ? 0 : ((k - 8 < 3) ? k - 8 : 3)));
      chk($sformatf("d2.fill%0d.overflow", k), 64'(overflow2), 64'(k > 8));
      chk($sformatf("d2.fill%0d.head", k), out_data2, 64'd1);
    end
    chk("d2.stall", 64'(cpu_stall2), 64'd1);
    io_write2 = 1'b0; out_ready2 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("d2.drain%0d.valid", k), 64'(out_valid2), 64'd1);
      chk($sformatf("d2.drain%0d.data", k), out_data2, 64'(k));
      @(posedge clk); #1;
      chk($sformatf("d2.drain%0d.level", k), 64'(level2), 64'(8 - k));
    end
    chk("d2.empty_valid", 64'(out_valid2), 64'd0);
    chk("d2.cnt_held", 64'(overflow_cnt2), 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
